// File: rtl/pin_walk_sequencer_pkg.sv
// Shared encodings for the pin walking-light sequencer: scheduler modes and walk direction.
package pin_walk_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'd0,
    MODE_WALK   = 2'd1,
    MODE_BOUNCE = 2'd2
  } mode_e;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton front end: synchroniser, debounce, hold timer and SHORT/LONG press pulses.
module btn_debounce #(
  parameter int unsigned DEB_LOG2  = 16,
  parameter int unsigned LONG_LOG2 = 23
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_ni,
  output logic held_o,
  output logic short_evt_o,
  output logic long_evt_o
);

  localparam logic [DEB_LOG2-1:0] DebMax   = '1;
  localparam logic [LONG_LOG2:0]  HoldMax  = {1'b1, {LONG_LOG2{1'b0}}};
  localparam logic [LONG_LOG2:0]  HoldLast = HoldMax - 1'b1;

  logic [1:0]           sync_q, sync_d;
  logic [1:0]           settle_q, settle_d;
  logic                 armed_q, armed_d;
  logic                 held_q, held_d;
  logic [DEB_LOG2-1:0]  deb_cnt_q, deb_cnt_d;
  logic [LONG_LOG2:0]   hold_cnt_q, hold_cnt_d;
  logic                 long_done_q, long_done_d;
  logic                 short_q, short_d;
  logic                 press, release_evt;

  always_comb begin
    // Synchroniser stores the held level, so a cleared flop means released.
    sync_d   = {sync_q[0], ~btn_ni};
    settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
    // A button held through reset must be seen released before it can count as a press.
    armed_d  = armed_q | ((settle_q == 2'd3) & ~sync_q[1]);

    held_d    = held_q;
    deb_cnt_d = '0;
    if (sync_q[1] != held_q) begin
      if (deb_cnt_q == DebMax) begin
        if (armed_q) held_d = sync_q[1];
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end

    press       = held_d & ~held_q;
    release_evt = held_q & ~held_d;

    hold_cnt_d = hold_cnt_q;
    if (press) begin
      hold_cnt_d = '0;
    end else if (held_q && (hold_cnt_q != HoldMax)) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end

    long_evt_o  = held_q & (hold_cnt_q == HoldLast);
    long_done_d = press ? 1'b0 : (long_done_q | long_evt_o);
    short_d     = release_evt & ~long_done_q & ~long_evt_o;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q      <= '0;
      settle_q    <= '0;
      armed_q     <= 1'b0;
      held_q      <= 1'b0;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      long_done_q <= 1'b0;
      short_q     <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
      held_q      <= held_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      long_done_q <= long_done_d;
      short_q     <= short_d;
    end
  end

  assign held_o      = held_q;
  assign short_evt_o = short_q;

endmodule

// File: rtl/pin_walk_sequencer.sv
// One-hot walking light on NPINS outputs with manual, auto-walk and auto-bounce scheduling.
module pin_walk_sequencer
  import pin_walk_sequencer_pkg::*;
#(
  parameter int unsigned NPINS     = 24,
  parameter int unsigned LOG2DELAY = 20,
  parameter int unsigned DEB_LOG2  = 16,
  parameter int unsigned LONG_LOG2 = 23
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             BTN_N,
  output logic [NPINS-1:0] PINS,
  output logic [4:0]       POS,
  output logic [1:0]       MODE,
  output logic             DIR,
  output logic             LEDG_N
);

  localparam logic [4:0] PosLast   = 5'(NPINS - 1);
  localparam logic [4:0] PosPenult = 5'(NPINS - 2);

  mode_e                mode_q, mode_d;
  logic                 dir_q, dir_d;
  logic [4:0]           pos_q, pos_d;
  logic [LOG2DELAY-1:0] tick_q, tick_d;
  logic                 held, short_evt, long_evt;
  logic                 tick, step;

  btn_debounce #(
    .DEB_LOG2 (DEB_LOG2),
    .LONG_LOG2(LONG_LOG2)
  ) u_btn (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .btn_ni     (BTN_N),
    .held_o     (held),
    .short_evt_o(short_evt),
    .long_evt_o (long_evt)
  );

  always_comb begin
    mode_d = mode_q;
    dir_d  = dir_q;
    pos_d  = pos_q;
    tick_d = tick_q + 1'b1;
    step   = 1'b0;
    tick   = (mode_q != MODE_MANUAL) && (tick_q == '1);

    if (long_evt) begin
      tick_d = '0;
      unique case (mode_q)
        MODE_MANUAL: mode_d = MODE_WALK;
        MODE_WALK:   mode_d = MODE_BOUNCE;
        default:     mode_d = MODE_MANUAL;
      endcase
    end else if (mode_q == MODE_MANUAL) begin
      tick_d = '0;
      step   = short_evt;
    end else begin
      // Reversal takes effect before a coincident tick step.
      if (short_evt) dir_d = ~dir_q;
      step = tick;
    end

    if (step) begin
      if ((mode_q == MODE_BOUNCE) && (dir_d == DIR_UP) && (pos_q == PosLast)) begin
        dir_d = DIR_DN;
        pos_d = PosPenult;
      end else if ((mode_q == MODE_BOUNCE) && (dir_d == DIR_DN) && (pos_q == 5'd0)) begin
        dir_d = DIR_UP;
        pos_d = 5'd1;
      end else if (dir_d == DIR_UP) begin
        pos_d = (pos_q == PosLast) ? 5'd0 : pos_q + 5'd1;
      end else begin
        pos_d = (pos_q == 5'd0) ? PosLast : pos_q - 5'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_q <= MODE_MANUAL;
      dir_q  <= DIR_UP;
      pos_q  <= '0;
      tick_q <= '0;
    end else begin
      mode_q <= mode_d;
      dir_q  <= dir_d;
      pos_q  <= pos_d;
      tick_q <= tick_d;
    end
  end

  always_comb begin
    PINS = '0;
    for (int i = 0; i < NPINS; i++) begin
      PINS[i] = (pos_q == 5'(i));
    end
  end

  assign POS    = pos_q;
  assign MODE   = mode_q;
  assign DIR    = dir_q;
  assign LEDG_N = ~held;

endmodule

// File: tb/tb_pin_walk_sequencer.sv
// Randomised self-checking bench for pin_walk_sequencer against an event-level reference model.
module tb_pin_walk_sequencer;

  localparam int NP     = 24;
  localparam int PERIOD = 8;   // 2^LOG2DELAY
  localparam int LONG_N = 32;  // hold cycles that yield a LONG press (2^LONG_LOG2)

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          BTN_N = 1'b1;
  logic [NP-1:0] PINS;
  logic [4:0]    POS;
  logic [1:0]    MODE;
  logic          DIR;
  logic          LEDG_N;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int short_at = -1;
  int long_at = -1;
  int auto_start = 0;
  int m_pos = 0;
  int m_mode = 0;
  bit m_dir = 1'b0;

  always #5 CLK = ~CLK;

  pin_walk_sequencer #(
    .NPINS    (NP),
    .LOG2DELAY(3),
    .DEB_LOG2 (2),
    .LONG_LOG2(5)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .BTN_N (BTN_N),
    .PINS  (PINS),
    .POS   (POS),
    .MODE  (MODE),
    .DIR   (DIR),
    .LEDG_N(LEDG_N)
  );

  function automatic logic [NP-1:0] onehot(input int p);
    logic [NP-1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  function automatic int stepped(input int p, input bit d);
    return d ? (p + NP - 1) % NP : (p + 1) % NP;
  endfunction

  // Reference model: button events land at fixed latencies after the press, auto steps
  // every PERIOD cycles counted from the last mode change.
  task automatic model_edge();
    bit tick;
    cyc++;
    if (!RST_N) return;
    if (cyc == long_at) begin
      m_mode = (m_mode + 1) % 3;
      auto_start = cyc;
      long_at = -1;
      return;
    end
    tick = (m_mode != 0) && (cyc > auto_start) && ((cyc - auto_start) % PERIOD == 0);
    if (cyc == short_at) begin
      short_at = -1;
      if (m_mode == 0) m_pos = stepped(m_pos, m_dir);
      else m_dir = !m_dir;
    end
    if (tick) begin
      if (m_mode == 2 && !m_dir && m_pos == NP - 1) begin
        m_dir = 1'b1;
        m_pos = NP - 2;
      end else if (m_mode == 2 && m_dir && m_pos == 0) begin
        m_dir = 1'b0;
        m_pos = 1;
      end else begin
        m_pos = stepped(m_pos, m_dir);
      end
    end
  endtask

  initial forever begin
    @(posedge CLK);
    model_edge();
  end

  task automatic model_reset();
    m_pos = 0;
    m_mode = 0;
    m_dir = 1'b0;
    short_at = -1;
    long_at = -1;
    auto_start = cyc;
  endtask

  // Called at a falling edge just before BTN_N goes low. Latencies: 2 sync + 4 debounce
  // cycles to qualify, LONG after 32 held cycles, SHORT one cycle after the debounced release.
  task automatic sched_press(input int n);
    if (n >= LONG_N) long_at = cyc + 1 + 37;
    else if (n >= 6) short_at = cyc + 1 + n + 6;
  endtask

  task automatic press(input int n);
    sched_press(n);
    BTN_N = 1'b0;
    repeat (n) @(negedge CLK);
    BTN_N = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    idle(3);
    model_reset();
    RST_N = 1'b1;
    idle(50);
    checks++; if (POS !== 5'd0) begin errors++; $display("FAIL reset_pos: got %0d want 0", POS); end
    checks++; if (PINS !== 24'h000001) begin errors++; $display("FAIL reset_pins: got %h want 000001", PINS); end
    checks++; if (MODE !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d want 0", MODE); end
    checks++; if (DIR !== 1'b0) begin errors++; $display("FAIL reset_dir: got %0d want 0", DIR); end
    checks++; if (LEDG_N !== 1'b1) begin errors++; $display("FAIL reset_ledg: got %0d want 1", LEDG_N); end
  endtask

  task automatic test_manual();
    for (int i = 0; i < NP; i++) begin
      press($urandom_range(6, 20));
      idle($urandom_range(8, 16));
      checks++;
      if (POS !== 5'((i + 1) % NP)) begin
        errors++; $display("FAIL manual_pos[%0d]: got %0d want %0d", i, POS, (i + 1) % NP);
      end
      checks++;
      if (PINS !== onehot(m_pos)) begin
        errors++; $display("FAIL manual_pins[%0d]: got %h want %h", i, PINS, onehot(m_pos));
      end
      if (i == NP - 2) begin
        checks++;
        if (PINS[NP-1] !== 1'b1) begin errors++; $display("FAIL manual_top_bit: got 0 want 1"); end
      end
    end
    checks++; if (DIR !== 1'b0) begin errors++; $display("FAIL manual_dir: got %0d want 0", DIR); end
  endtask

  task automatic test_glitch();
    BTN_N = 1'b0;
    idle(2);
    BTN_N = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      checks++;
      if (LEDG_N !== 1'b1) begin errors++; $display("FAIL glitch_ledg[%0d]: got %0d want 1", i, LEDG_N); end
    end
    checks++; if (POS !== 5'(m_pos)) begin errors++; $display("FAIL glitch_pos: got %0d want %0d", POS, m_pos); end
    checks++; if (MODE !== 2'd0) begin errors++; $display("FAIL glitch_mode: got %0d want 0", MODE); end
  endtask

  task automatic test_long_walk();
    int prev, last_step, wraps;
    sched_press(40);
    BTN_N = 1'b0;
    idle(20);
    checks++; if (LEDG_N !== 1'b0) begin errors++; $display("FAIL long_ledg: got %0d want 0", LEDG_N); end
    idle(20);
    BTN_N = 1'b1;
    checks++; if (MODE !== 2'd1) begin errors++; $display("FAIL long_mode: got %0d want 1", MODE); end
    prev = POS;
    last_step = -1;
    wraps = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      checks++;
      if (POS !== 5'(m_pos) || DIR !== m_dir || MODE !== 2'd1) begin
        errors++;
        $display("FAIL walk[%0d]: got pos=%0d dir=%0d mode=%0d want pos=%0d dir=%0d mode=1",
                 i, POS, DIR, MODE, m_pos, m_dir);
      end
      if (int'(POS) != prev) begin
        if (last_step >= 0) begin
          checks++;
          if (i - last_step != PERIOD) begin
            errors++; $display("FAIL walk_period: got %0d want %0d", i - last_step, PERIOD);
          end
        end
        if (prev == NP - 1 && POS == 5'd0) wraps++;
        last_step = i;
        prev = POS;
      end
    end
    checks++; if (wraps == 0) begin errors++; $display("FAIL walk_wrap: got 0 wraps want >0"); end
  endtask

  task automatic test_bounce();
    int prev, top_seen, bot_seen, btn_left, cool, n;
    press(40);
    idle(12);
    checks++; if (MODE !== 2'd2) begin errors++; $display("FAIL bounce_mode: got %0d want 2", MODE); end
    prev = POS;
    top_seen = 0;
    bot_seen = 0;
    for (int i = 0; i < 420; i++) begin
      @(negedge CLK);
      checks++;
      if (POS !== 5'(m_pos) || DIR !== m_dir) begin
        errors++;
        $display("FAIL bounce[%0d]: got pos=%0d dir=%0d want pos=%0d dir=%0d", i, POS, DIR, m_pos, m_dir);
      end
      if (prev == NP - 1 && POS == 5'(NP - 2) && DIR == 1'b1) top_seen++;
      if (prev == 0 && POS == 5'd1 && DIR == 1'b0) bot_seen++;
      prev = POS;
    end
    checks++; if (top_seen == 0) begin errors++; $display("FAIL bounce_top: got 0 want >0"); end
    checks++; if (bot_seen == 0) begin errors++; $display("FAIL bounce_bottom: got 0 want >0"); end
    btn_left = 0;
    cool = 0;
    for (int i = 0; i < 320; i++) begin
      if (btn_left > 0) begin
        btn_left--;
        if (btn_left == 0) begin BTN_N = 1'b1; cool = 12; end
      end else if (cool > 0) begin
        cool--;
      end else if (i < 290 && $urandom_range(0, 30) == 0) begin
        n = $urandom_range(6, 20);
        sched_press(n);
        BTN_N = 1'b0;
        btn_left = n;
      end
      @(negedge CLK);
      checks++;
      if (POS !== 5'(m_pos) || DIR !== m_dir || POS >= 5'(NP)) begin
        errors++;
        $display("FAIL bounce_short[%0d]: got pos=%0d dir=%0d want pos=%0d dir=%0d",
                 i, POS, DIR, m_pos, m_dir);
      end
    end
  endtask

  task automatic test_short_on_tick();
    bit found;
    press(40);
    idle(12);
    press(40);
    idle(12);
    checks++; if (MODE !== 2'd1) begin errors++; $display("FAIL tick_mode: got %0d want 1", MODE); end
    if (m_dir) begin
      press(8);
      idle(10);
    end
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge CLK);
      if (m_pos == 3 && !m_dir && (cyc - auto_start) % PERIOD == 0 && cyc > auto_start) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL tick_align: got no aligned step within budget want one");
    end else begin
      checks++; if (POS !== 5'd3) begin errors++; $display("FAIL tick_pre_pos: got %0d want 3", POS); end
      // Release so the SHORT lands on the step edge that leaves POS=5.
      press(17);
      idle(7);
      checks++; if (DIR !== 1'b1) begin errors++; $display("FAIL tick_dir: got %0d want 1", DIR); end
      checks++; if (POS !== 5'd4) begin errors++; $display("FAIL tick_pos: got %0d want 4", POS); end
      checks++;
      if (POS !== 5'(m_pos) || DIR !== m_dir) begin
        errors++; $display("FAIL tick_model: got pos=%0d dir=%0d want pos=%0d dir=%0d", POS, DIR, m_pos, m_dir);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    BTN_N = 1'b0;
    idle(15);
    RST_N = 1'b0;
    model_reset();
    #1;
    checks++;
    if (POS !== 5'd0 || PINS !== 24'h000001 || MODE !== 2'd0 || DIR !== 1'b0 || LEDG_N !== 1'b1) begin
      errors++;
      $display("FAIL midreset_outputs: got pos=%0d pins=%h mode=%0d dir=%0d ledg=%0d want 0 000001 0 0 1",
               POS, PINS, MODE, DIR, LEDG_N);
    end
    idle(3);
    RST_N = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      checks++;
      if (LEDG_N !== 1'b1 || MODE !== 2'd0 || POS !== 5'd0) begin
        errors++;
        $display("FAIL midreset_hold[%0d]: got ledg=%0d mode=%0d pos=%0d want 1 0 0", i, LEDG_N, MODE, POS);
      end
    end
    BTN_N = 1'b1;
    idle(20);
    checks++; if (POS !== 5'd0) begin errors++; $display("FAIL midreset_release: got %0d want 0", POS); end
    press(10);
    idle(12);
    checks++; if (POS !== 5'd1) begin errors++; $display("FAIL midreset_fresh: got %0d want 1", POS); end
    checks++; if (POS !== 5'(m_pos)) begin errors++; $display("FAIL midreset_model: got %0d want %0d", POS, m_pos); end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    @(negedge CLK);
    test_reset();
    test_manual();
    test_glitch();
    test_long_walk();
    test_bounce();
    test_short_on_tick();
    test_reset_mid_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
